vga_bounce_pic: RTL



---
 rtl/vga_bounce_pic_if.sv | 13 +
 rtl/vga_bounce_pic.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_bounce_pic_if.sv
// Pixel-side bus between the VGA timing controller and the bouncing-box generator.
interface vga_bounce_pic_if;
  logic        move_en;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pix_data;
  logic        bounce;

  // Timing controller side: presents coordinates, consumes colour.
  modport master (output move_en, pix_x, pix_y, input pix_data, bounce);
  // Generator side.
  modport slave  (input move_en, pix_x, pix_y, output pix_data, bounce);
endinterface

// File: rtl/vga_bounce_pic.sv
// Bouncing-box pixel generator: a solid box over a fixed background that moves
// once per frame, reflects off the screen edges and recolours on each bounce.
module vga_bounce_pic #(
  parameter int          H_VALID  = 640,
  parameter int          V_VALID  = 480,
  parameter int          BOX_W    = 64,
  parameter int          BOX_H    = 64,
  parameter int          STEP     = 2,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  vga_bounce_pic_if.slave   bus
);
  localparam int X_MAX = H_VALID - BOX_W;
  localparam int Y_MAX = V_VALID - BOX_H;

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0]  color_idx_q, color_idx_d;
  logic        frame_end_q, frame_end_d;
  logic [11:0] pix_data_q, pix_data_d;
  logic        bounce_q, bounce_d;

  logic [10:0] px, py, bx, by;
  logic        valid, inbox;
  logic [11:0] box_color;
  logic [9:0]  x_mv, y_mv;
  logic        dx_mv, dy_mv, hit_x, hit_y;

  // Palette lookup for the current box colour.
  always_comb begin
    case (color_idx_q)
      3'd0:    box_color = 12'hF00;
      3'd1:    box_color = 12'h0F0;
      3'd2:    box_color = 12'h00F;
      3'd3:    box_color = 12'hFF0;
      3'd4:    box_color = 12'h0FF;
      3'd5:    box_color = 12'hF0F;
      3'd6:    box_color = 12'hFFF;
      default: box_color = 12'hF80;
    endcase
  end

  // Pixel path; compared in 11 bits so box edge + size cannot wrap.
  always_comb begin
    px    = {1'b0, bus.pix_x};
    py    = {1'b0, bus.pix_y};
    bx    = {1'b0, box_x_q};
    by    = {1'b0, box_y_q};
    valid = (px < 11'(H_VALID)) && (py < 11'(V_VALID));
    inbox = (px >= bx) && (px < bx + 11'(BOX_W)) &&
            (py >= by) && (py < by + 11'(BOX_H));
    if (!valid)     pix_data_d = 12'h000;
    else if (inbox) pix_data_d = box_color;
    else            pix_data_d = BG_COLOR;
    frame_end_d = (bus.pix_x == 10'(H_VALID - 1)) && (bus.pix_y == 10'(V_VALID - 1));
  end

  // Candidate per-axis moves with edge reflection.
  always_comb begin
    x_mv = box_x_q; dx_mv = dir_x_q; hit_x = 1'b0;
    if (!dir_x_q) begin
      if (bx + 11'(STEP) >= 11'(X_MAX)) begin
        x_mv = 10'(X_MAX); dx_mv = 1'b1; hit_x = 1'b1;
      end else x_mv = box_x_q + 10'(STEP);
    end else begin
      if (box_x_q <= 10'(STEP)) begin
        x_mv = 10'd0; dx_mv = 1'b0; hit_x = 1'b1;
      end else x_mv = box_x_q - 10'(STEP);
    end
    y_mv = box_y_q; dy_mv = dir_y_q; hit_y = 1'b0;
    if (!dir_y_q) begin
      if (by + 11'(STEP) >= 11'(Y_MAX)) begin
        y_mv = 10'(Y_MAX); dy_mv = 1'b1; hit_y = 1'b1;
      end else y_mv = box_y_q + 10'(STEP);
    end else begin
      if (box_y_q <= 10'(STEP)) begin
        y_mv = 10'd0; dy_mv = 1'b0; hit_y = 1'b1;
      end else y_mv = box_y_q - 10'(STEP);
    end
  end

  // Update FSM: one UPDATE cycle per enabled frame end commits the move.
  always_comb begin
    state_d     = state_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    color_idx_d = color_idx_q;
    bounce_d    = 1'b0;
    case (state_q)
      IDLE: if (frame_end_q && bus.move_en) state_d = UPDATE;
      UPDATE: begin
        state_d = IDLE;
        box_x_d = x_mv; dir_x_d = dx_mv;
        box_y_d = y_mv; dir_y_d = dy_mv;
        // A corner counts as a single bounce.
        if (hit_x || hit_y) begin
          color_idx_d = color_idx_q + 3'd1;
          bounce_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; synchronous reset overrides any pending update.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      color_idx_q <= '0;
      frame_end_q <= 1'b0;
      pix_data_q  <= '0;
      bounce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      color_idx_q <= color_idx_d;
      frame_end_q <= frame_end_d;
      pix_data_q  <= pix_data_d;
      bounce_q    <= bounce_d;
    end
  end

  assign bus.pix_data = pix_data_q;
  assign bus.bounce   = bounce_q;
endmodule
